rv32i_bus_responder: RTL

Bus responder for the RV32I core's memory bus. It services the core's fetch, load and store requests on `bus_addr`/`bus_wrdata`/`bus_wren`/`bus_rden`/`bus_rddata`. It combines a word-organised on-chip RAM with a small memory-mapped peripheral window containing a GPIO output register, a free-running timer with compare interrupt, and a status register. It sits between the core and the top level, and replaces the bare memory model used in early bring-up.

---
 rtl/rv32i_bus_responder.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/rv32i_bus_responder.sv
// -----------------------------------------------------------------------------
// rv32i_bus_responder
//
// Memory-bus slave for the RV32I core: a word-organised on-chip RAM plus a
// 32-byte peripheral window (GPIO output, free-running timer with compare
// interrupt, status register). Every request completes in one cycle; read
// data and the error pulse are registered.
//
// Ports
//   clk         : single clock, rising edge
//   rst         : asynchronous active-low reset
//   bus_addr    : byte address from the core
//   bus_wrdata  : store data, right-justified
//   bus_wren    : write request (one cycle per store)
//   bus_rden    : read request (one cycle per fetch/load)
//   bus_size    : 00 byte, 01 half, 10 word, 11 illegal
//   bus_rddata  : registered full aligned word, held until the next read
//   bus_err     : one-cycle pulse after an erroneous request
//   gpio_out    : GPIO output register
//   timer_irq   : registered timer interrupt level
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module rv32i_bus_responder #(
   parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
   parameter int unsigned RAM_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE = 32'h0001_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] bus_addr,
   input  logic [31:0] bus_wrdata,
   input  logic        bus_wren,
   input  logic        bus_rden,
   input  logic [1:0]  bus_size,
   output logic [31:0] bus_rddata,
   output logic        bus_err,
   output logic [31:0] gpio_out,
   output logic        timer_irq
);

   localparam int unsigned AW        = $clog2(RAM_WORDS);
   localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

   // Peripheral word offsets (bus_addr[4:2])
   localparam logic [2:0] MMIO_GPIO   = 3'd0;
   localparam logic [2:0] MMIO_CTRL   = 3'd1;
   localparam logic [2:0] MMIO_MTIME  = 3'd2;
   localparam logic [2:0] MMIO_CMP    = 3'd3;
   localparam logic [2:0] MMIO_STATUS = 3'd4;

   logic [31:0]   r_mem [RAM_WORDS];
   logic [31:0]   r_rddata;
   logic          r_err;
   logic [31:0]   r_gpio;
   logic [1:0]    r_tctrl;
   logic [31:0]   r_mtime;
   logic [31:0]   r_mtimecmp;
   logic          r_sticky;
   logic          r_irq;

   logic [31:0]   w_ram_off;
   logic          w_ram_hit;
   logic          w_mmio_hit;
   logic [AW-1:0] w_idx;
   logic [2:0]    w_reg;
   logic          w_misalign;
   logic          w_fault;
   logic          w_err;
   logic          w_wr;
   logic          w_ram_wr;
   logic          w_mmio_wr;
   logic          w_rd;
   logic          w_pending;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata;
   logic [31:0]   w_mmio_rdata;
   logic [31:0]   w_rd_word;

   // ---------------- decode and error classification ----------------
   // Subtracting the base makes addresses below RAM_BASE wrap to huge
   // offsets, so a single unsigned compare covers both range bounds.
   assign w_ram_off  = bus_addr - RAM_BASE;
   assign w_ram_hit  = (w_ram_off < RAM_BYTES);
   assign w_mmio_hit = (bus_addr[31:5] == MMIO_BASE[31:5]);
   assign w_idx      = bus_addr[AW+1:2];
   assign w_reg      = bus_addr[4:2];

   assign w_misalign = ((bus_size == 2'b01) && bus_addr[0]) ||
                       ((bus_size == 2'b10) && (bus_addr[1:0] != 2'b00));

   // Every fault except the simultaneous-request one; those suppress the write.
   assign w_fault = (bus_wren || bus_rden) &&
                    (!(w_ram_hit || w_mmio_hit) || w_misalign ||
                     (bus_size == 2'b11) ||
                     (bus_wren && w_mmio_hit && (bus_size != 2'b10)));
   assign w_err   = w_fault || (bus_wren && bus_rden);

   // A simultaneous read+write that is otherwise legal still performs the
   // write. Writes presented while reset is held are dropped.
   assign w_wr      = bus_wren && !w_fault && rst;
   assign w_ram_wr  = w_wr && w_ram_hit;
   assign w_mmio_wr = w_wr && w_mmio_hit;
   assign w_rd      = bus_rden && !bus_wren;

   assign w_pending = (r_mtime >= r_mtimecmp);

   // ---------------- store lane steering ----------------
   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      w_be    = 4'b0000;
      w_wdata = bus_wrdata;
      case (bus_size)
         2'b00: begin
            w_be[bus_addr[1:0]] = 1'b1;
            w_wdata             = {4{bus_wrdata[7:0]}};
         end
         2'b01: begin
            w_be    = bus_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{bus_wrdata[15:0]}};
         end
         default: w_be = 4'b1111;
      endcase
   end

   // NOTE: the RAM array has no reset; its contents are undefined after
   // power-up, and keeping it out of the reset tree lets it map to block RAM.
   always_ff @(posedge clk) begin
      if (w_ram_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
         end
      end
   end

   // ---------------- read mux ----------------
   always_comb begin
      w_mmio_rdata = '0;
      case (w_reg)
         MMIO_GPIO:   w_mmio_rdata = r_gpio;
         MMIO_CTRL:   w_mmio_rdata = {30'b0, r_tctrl};
         MMIO_MTIME:  w_mmio_rdata = r_mtime;
         MMIO_CMP:    w_mmio_rdata = r_mtimecmp;
         MMIO_STATUS: w_mmio_rdata = {30'b0, r_sticky, w_pending};
         default:     w_mmio_rdata = '0;
      endcase
   end

   assign w_rd_word = w_ram_hit ? r_mem[w_idx] : w_mmio_rdata;

   // ---------------- registered state ----------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rddata   <= '0;
         r_err      <= 1'b0;
         r_gpio     <= '0;
         r_tctrl    <= '0;
         r_mtime    <= '0;
         r_mtimecmp <= 32'hFFFF_FFFF;
         r_sticky   <= 1'b0;
         r_irq      <= 1'b0;
      end else begin
         r_err <= w_err;
         r_irq <= w_pending && r_tctrl[1];

         if (w_rd) r_rddata <= w_fault ? 32'h0 : w_rd_word;

         if (w_mmio_wr && (w_reg == MMIO_GPIO)) r_gpio     <= bus_wrdata;
         if (w_mmio_wr && (w_reg == MMIO_CTRL)) r_tctrl    <= bus_wrdata[1:0];
         if (w_mmio_wr && (w_reg == MMIO_CMP))  r_mtimecmp <= bus_wrdata;

         // A store to MTIME overrides the increment in the same cycle.
         if (w_mmio_wr && (w_reg == MMIO_MTIME)) r_mtime <= bus_wrdata;
         else if (r_tctrl[0])                    r_mtime <= r_mtime + 32'd1;

         if (w_err)
            r_sticky <= 1'b1;
         else if (w_mmio_wr && (w_reg == MMIO_STATUS) && bus_wrdata[1])
            r_sticky <= 1'b0;
      end
   end

   assign bus_rddata = r_rddata;
   assign bus_err    = r_err;
   assign gpio_out   = r_gpio;
   assign timer_irq  = r_irq;

endmodule
